// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS32 load/store port: one request at a time,
// LATENCY wait states, byte-enabled word write or word read, registered response.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_alive;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_be_ok;
  logic                  w_misalign;
  logic                  w_oob;
  logic                  w_fault;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign req_ready  = r_alive && (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign w_accept   = req_valid && req_ready;
  assign w_idx      = r_addr[ADDR_WIDTH+1:2];

  // Fault is judged on the captured request, so late changes on req_* are ignored.
  always_comb begin
    w_be_ok    = 1'b0;
    w_misalign = 1'b0;
    case (r_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_be_ok = 1'b1;
      4'b0011, 4'b1100: begin
        w_be_ok    = 1'b1;
        w_misalign = r_addr[0];
      end
      4'b1111: begin
        w_be_ok    = 1'b1;
        w_misalign = |r_addr[1:0];
      end
      default: w_be_ok = 1'b0;
    endcase
    w_oob   = (r_addr >> (ADDR_WIDTH + 2)) != '0;
    w_fault = w_oob || !w_be_ok || w_misalign;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 0) begin
            w_state_nxt = S_ACCESS;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_ACCESS;
        else             w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   if (resp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
      if (r_state == S_ACCESS) begin
        r_err   <= w_fault;
        r_rdata <= (r_we || w_fault) ? '0 : r_mem[w_idx];
      end
    end
  end

  // Array has no reset; an async reset clears r_state, which cancels a pending write.
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && r_we && !w_fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule
